fir_filter_param: RTL and testbench

FIR_FILTER_PARAM -- requirements
Module: fir_filter_param

---
 rtl/dsp_pkg.sv | 36 +++
 rtl/fir_mac.sv | 45 ++++
 rtl/fir_filter_param.sv | 163 ++++++++++++++++
 tb/tb_fir_filter_param.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_pkg
//  Description : Shared definitions for the FIR filter: FSM state encoding
//                and the rounding / saturation helper constants. The helpers
//                return 64-bit signed values; callers size-cast them to
//                their own datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsp_pkg;

  // FIR sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  // Half-LSB rounding bias for a right shift of 'shift' bits (0 when no shift)
  function automatic logic signed [63:0] round_bias(input int shift);
    if (shift <= 0) return 64'sd0;
    return 64'sd1 <<< (shift - 1);
  endfunction

  // Largest value representable in a w-bit two's complement word
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement word
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac
//  Description : Signed multiply-accumulate unit. One product a_i*b_i is
//                added to the accumulator per enabled cycle; clear_i zeroes
//                the accumulator and takes priority over en_i.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                clear_i        - zero the accumulator on the next edge
//                en_i           - accumulate a_i*b_i on the next edge
//                a_i, b_i       - signed operands (sample, coefficient)
//                acc_o          - signed accumulator value
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [COEF_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         acc_q;

  assign prod  = a_i * b_i;
  assign acc_o = acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_filter_param.sv
`default_nettype none
// ============================================================================
//  Module      : fir_filter_param
//  Description : Parameterised FIR filter, y[n] = sum c[k]*x[n-k], computed
//                with a single time-multiplexed MAC. One sample is accepted
//                in IDLE, TAPS MAC cycles follow, then one OUT cycle rounds,
//                scales and saturates the result.
//  Ports       : clk, rst              - clock, asynchronous active-high reset
//                in_valid/in_ready, xn - sample input handshake and data
//                coef_we, coef_addr,
//                coef_wdata, coef_ready - coefficient write port (IDLE only)
//                out_valid             - one-cycle pulse, yn/sat_flag new
//                yn, sat_flag          - held result and saturation flag
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_filter_param
  import dsp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 15,
  parameter int SHIFT  = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   xn,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  output logic                       coef_ready,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   yn,
  output logic                       sat_flag
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;
  // One extra bit so adding the rounding bias can never wrap
  localparam int SUM_W  = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] RND_BIAS = SUM_W'(round_bias(SHIFT));
  localparam logic signed [SUM_W-1:0] Y_MAX    = SUM_W'(sat_max(DATA_W));
  localparam logic signed [SUM_W-1:0] Y_MIN    = SUM_W'(sat_min(DATA_W));
  localparam logic [ADDR_W-1:0]       LAST_TAP = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W:0]         TAPS_EXT = (ADDR_W + 1)'(TAPS);

  fir_state_e                state_q;
  logic [ADDR_W-1:0]         cnt_q;
  logic signed [DATA_W-1:0]  x_q    [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [DATA_W-1:0]  yn_q;
  logic                      sat_q;
  logic                      out_valid_q;

  logic                      accept;
  logic                      coef_take;
  logic                      mac_clr;
  logic                      mac_en;
  logic signed [ACC_W-1:0]   acc;
  logic signed [SUM_W-1:0]   rounded;
  logic signed [SUM_W-1:0]   scaled;
  logic signed [DATA_W-1:0]  yn_d;
  logic                      sat_d;

  assign in_ready   = (state_q == ST_IDLE);
  assign coef_ready = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign yn         = yn_q;
  assign sat_flag   = sat_q;

  assign accept    = in_valid && in_ready;
  // Zero-extend the address so TAPS itself is representable in the compare
  assign coef_take = coef_we && coef_ready && ({1'b0, coef_addr} < TAPS_EXT);

  // Accumulator is cleared on the accepting edge, then takes one tap per MAC cycle
  assign mac_clr = accept;
  assign mac_en  = (state_q == ST_MAC);

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clear_i (mac_clr),
    .en_i    (mac_en),
    .a_i     (x_q[cnt_q]),
    .b_i     (coef_q[cnt_q]),
    .acc_o   (acc)
  );

  // Round half-up, arithmetic shift, then clamp to the output range
  assign rounded = SUM_W'(acc) + RND_BIAS;
  assign scaled  = rounded >>> SHIFT;

  always_comb begin
    yn_d  = scaled[DATA_W-1:0];
    sat_d = 1'b0;
    if (scaled > Y_MAX) begin
      yn_d  = Y_MAX[DATA_W-1:0];
      sat_d = 1'b1;
    end else if (scaled < Y_MIN) begin
      yn_d  = Y_MIN[DATA_W-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      yn_q        <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;

      // Written on the accepting edge, so MAC already sees the new value
      if (coef_take) begin
        coef_q[coef_addr] <= coef_wdata;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              x_q[k] <= x_q[k-1];
            end
            x_q[0]  <= xn;
            cnt_q   <= '0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (cnt_q == LAST_TAP) begin
            cnt_q   <= '0;
            state_q <= ST_OUT;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        ST_OUT: begin
          yn_q        <= yn_d;
          sat_q       <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_filter_param
//  Description : Self-checking bench for fir_filter_param. Vector tables for
//                impulse and rounding responses, hand-written sequences for
//                saturation, backpressure, coefficient guard and mid-MAC
//                reset, plus randomized samples checked against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_filter_param;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 15;
  localparam int SHIFT  = 15;
  localparam int ADDR_W = $clog2(TAPS);

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] xn = '0;
  logic                     coef_we = 1'b0;
  logic [ADDR_W-1:0]        coef_addr = '0;
  logic signed [COEF_W-1:0] coef_wdata = '0;
  logic                     coef_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] yn;
  logic                     sat_flag;

  fir_filter_param #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .SHIFT  (SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .xn         (xn),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_ready (coef_ready),
    .out_valid  (out_valid),
    .yn         (yn),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  int mc   [TAPS];
  int hist [TAPS];

  int imp_c [TAPS] = '{338, 533, 1080, 1872, 2754, 3550, 4102, 4300,
                       4102, 3550, 2754, 1872, 1080, 533, 338};
  int imp_y [TAPS] = '{169, 267, 540, 936, 1377, 1775, 2051, 2150,
                       2051, 1775, 1377, 936, 540, 267, 169};

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) begin
      mc[k]   = 0;
      hist[k] = 0;
    end
  endfunction

  function automatic void model_push(input int x);
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endfunction

  function automatic void model_out(output int y, output int s);
    longint sum = 0;
    for (int k = 0; k < TAPS; k++) sum += longint'(mc[k]) * longint'(hist[k]);
    sum = (sum + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    s = 0;
    if (sum > 32767) begin
      sum = 32767;
      s = 1;
    end else if (sum < -32768) begin
      sum = -32768;
      s = 1;
    end
    y = int'(sum);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 64 && !in_ready; i++) tick();
    if (!in_ready) chk({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic write_coef(input int a, input int d);
    wait_idle("wcoef");
    coef_we    = 1'b1;
    coef_addr  = ADDR_W'(a);
    coef_wdata = COEF_W'(d);
    tick();
    coef_we = 1'b0;
    if (a < TAPS) mc[a] = d;
  endtask

  task automatic load_impulse_coefs();
    for (int k = 0; k < TAPS; k++) write_coef(k, imp_c[k]);
  endtask

  // Leaves the bench at one time step after the accepting edge
  task automatic send(input int x);
    wait_idle("send");
    in_valid = 1'b1;
    xn = DATA_W'(x);
    tick();
    in_valid = 1'b0;
    model_push(x);
  endtask

  // n0 = edges already elapsed since the accepting edge
  task automatic wait_out(input string name, input int n0, output int y, output int s);
    int n = n0;
    int ey, es;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 64);
    chk({name, "_lat"}, n, TAPS + 1);
    model_out(ey, es);
    y = int'(yn);
    s = int'(sat_flag);
    chk({name, "_y"}, y, ey);
    chk({name, "_sat"}, s, es);
  endtask

  task automatic sample(input string name, input int x, output int y, output int s);
    send(x);
    wait_out(name, 0, y, s);
  endtask

  typedef struct {
    int x;
    int y;
    int s;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int y, s;
    int rdy, cyc, idx, npulse, extra;
    int vals [3];
    int ey [3];
    int es [3];
    int pcyc [3];

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_coef_ready", coef_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_yn", yn, 0);
    chk("rst_sat", sat_flag, 0);

    // ---------------- vector table: impulse + rounding ----------------
    for (int i = 0; i < TAPS; i++) begin
      tbl[i].x = (i == 0) ? 16384 : 0;
      tbl[i].y = imp_y[i];
      tbl[i].s = 0;
    end
    tbl[15] = '{x: 16384,  y: 1, s: 0};
    tbl[16] = '{x: 16383,  y: 0, s: 0};
    tbl[17] = '{x: -16384, y: 0, s: 0};

    load_impulse_coefs();
    for (int i = 0; i < 18; i++) begin
      if (i == 15) begin
        write_coef(0, 1);
        for (int k = 1; k < TAPS; k++) write_coef(k, 0);
      end
      sample($sformatf("vec%0d", i), tbl[i].x, y, s);
      chk($sformatf("vec%0d_tbl_y", i), y, tbl[i].y);
      chk($sformatf("vec%0d_tbl_sat", i), s, tbl[i].s);
    end

    // ---------------- saturation ----------------
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int i = 0; i < TAPS; i++) sample("satp", 32767, y, s);
    chk("satp_final_y", y, 32767);
    chk("satp_final_sat", s, 1);
    for (int i = 0; i < TAPS; i++) sample("satn", -32768, y, s);
    chk("satn_final_y", y, -32768);
    chk("satn_final_sat", s, 1);

    // ---------------- backpressure: in_valid held for 3 samples ----------------
    do_reset();
    load_impulse_coefs();
    vals = '{1000, -2000, 3000};
    in_valid = 1'b1;
    xn = DATA_W'(vals[0]);
    idx = 0;
    cyc = 0;
    npulse = 0;
    while (cyc < 200 && npulse < 3) begin
      rdy = int'(in_ready);
      tick();
      cyc++;
      if (rdy != 0 && in_valid) begin
        model_push(vals[idx]);
        model_out(ey[idx], es[idx]);
        idx++;
        if (idx < 3) xn = DATA_W'(vals[idx]);
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        pcyc[npulse] = cyc;
        chk($sformatf("bp%0d_y", npulse), yn, ey[npulse]);
        chk($sformatf("bp%0d_sat", npulse), sat_flag, es[npulse]);
        npulse++;
      end
    end
    chk("bp_pulses", npulse, 3);
    chk("bp_accepts", idx, 3);
    if (npulse == 3) begin
      chk("bp_gap01", pcyc[1] - pcyc[0], TAPS + 2);
      chk("bp_gap12", pcyc[2] - pcyc[1], TAPS + 2);
    end
    extra = 0;
    for (int i = 0; i < 2 * (TAPS + 2); i++) begin
      tick();
      if (out_valid) extra++;
    end
    chk("bp_extra_pulses", extra, 0);

    // ---------------- coefficient guard ----------------
    send(7000);
    tick();
    tick();
    chk("guard_in_ready_mac", in_ready, 0);
    chk("guard_coef_ready_mac", coef_ready, 0);
    coef_we    = 1'b1;
    coef_addr  = '0;
    coef_wdata = COEF_W'(12345);
    tick();
    coef_we = 1'b0;
    wait_out("guard", 3, y, s);
    write_coef(TAPS, 9999);
    sample("guard_after", -5000, y, s);
    sample("guard_after2", 20000, y, s);

    // ---------------- coefficient write and sample acceptance together ----------------
    wait_idle("same");
    coef_we    = 1'b1;
    coef_addr  = ADDR_W'(2);
    coef_wdata = COEF_W'(-7777);
    in_valid   = 1'b1;
    xn         = DATA_W'(5000);
    tick();
    coef_we  = 1'b0;
    in_valid = 1'b0;
    mc[2] = -7777;
    model_push(5000);
    wait_out("same_cycle", 0, y, s);
    sample("same_next", 0, y, s);
    sample("same_next2", 0, y, s);

    // ---------------- reset during MAC ----------------
    send(16384);
    for (int i = 0; i < 4; i++) tick();
    chk("mrst_in_mac", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mrst_async_ready", in_ready, 1);
    chk("mrst_yn", yn, 0);
    chk("mrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("mrst_ready_after", in_ready, 1);
    extra = 0;
    for (int i = 0; i < TAPS + 6; i++) begin
      tick();
      if (out_valid) extra++;
    end
    chk("mrst_no_pulse", extra, 0);
    chk("mrst_yn_held", yn, 0);
    load_impulse_coefs();
    sample("mrst_zero", 0, y, s);
    chk("mrst_zero_const", y, 0);
    for (int i = 0; i < 3; i++) begin
      sample($sformatf("mrst_imp%0d", i), (i == 0) ? 16384 : 0, y, s);
      chk($sformatf("mrst_imp%0d_const", i), y, imp_y[i]);
    end

    // ---------------- randomized ----------------
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < 24; i++) begin
      sample($sformatf("rnd%0d", i), int'($urandom_range(0, 65535)) - 32768, y, s);
    end
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 4095)) - 2048);
    for (int i = 0; i < 16; i++) begin
      sample($sformatf("rndm%0d", i), int'($urandom_range(0, 65535)) - 32768, y, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
